// File: rtl/lklist_pkg.sv
// -----------------------------------------------------------------------------
// lklist_pkg
//   Shared definitions for the linked-list walker: reduction mode encodings,
//   the walker state encoding and the null-pointer value that ends a list.
//   No ports (package).
// -----------------------------------------------------------------------------
package lklist_pkg;

   // Reduction applied to the node values, selected at start time.
   typedef enum logic [1:0] {
      MODE_SUM   = 2'd0,
      MODE_COUNT = 2'd1,
      MODE_MAX   = 2'd2,
      MODE_FIND  = 2'd3
   } mode_e;

   // Walker states: each node costs a value fetch then a next-pointer fetch.
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_REQ_VAL  = 3'd1,
      ST_WAIT_VAL = 3'd2,
      ST_REQ_NXT  = 3'd3,
      ST_WAIT_NXT = 3'd4,
      ST_DONE     = 3'd5
   } state_e;

   // Address value that terminates a list (also means "empty list" as head).
   localparam int unsigned NULL_PTR = 32'd0;

endpackage : lklist_pkg

// File: rtl/lklist_acc.sv
// -----------------------------------------------------------------------------
// lklist_acc
//   Combinational mode-selected accumulate/compare unit. Holds no state; the
//   walker owns the accumulator register and decides when to load acc_nxt_o.
// Ports
//   mode_i     reduction mode
//   acc_i      current accumulator value
//   v_i        node value just returned by memory
//   key_i      FIND compare value
//   acc_nxt_o  accumulator value after folding in v_i
//   carry_o    SUM carried out of DATA_W
//   hit_o      FIND: v_i equals key_i
// -----------------------------------------------------------------------------
module lklist_acc
   import lklist_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  mode_e             mode_i,
   input  logic [DATA_W-1:0] acc_i,
   input  logic [DATA_W-1:0] v_i,
   input  logic [DATA_W-1:0] key_i,
   output logic [DATA_W-1:0] acc_nxt_o,
   output logic              carry_o,
   output logic              hit_o
);

   logic [DATA_W:0] sum_s;

   // Fold the node value into the accumulator according to the mode.
   always_comb begin
      // One extra bit so the carry-out of a wrapping add is visible.
      sum_s     = {1'b0, acc_i} + {1'b0, v_i};
      acc_nxt_o = acc_i;
      carry_o   = 1'b0;
      hit_o     = 1'b0;
      case (mode_i)
         MODE_SUM: begin
            acc_nxt_o = sum_s[DATA_W-1:0];
            carry_o   = sum_s[DATA_W];
         end
         MODE_COUNT: begin
            acc_nxt_o = acc_i + {{(DATA_W-1){1'b0}}, 1'b1};
         end
         MODE_MAX: begin
            if (v_i > acc_i) begin
               acc_nxt_o = v_i;
            end else begin
               acc_nxt_o = acc_i;
            end
         end
         MODE_FIND: begin
            hit_o = (v_i == key_i);
         end
         default: begin
            acc_nxt_o = acc_i;
         end
      endcase
   end

endmodule : lklist_acc

// File: rtl/lklist_walker.sv
// -----------------------------------------------------------------------------
// lklist_walker
//   Linked-list traversal engine. Each node occupies two words: the value at
//   addr and the next pointer at addr+1 (low ADDR_W bits). A null next
//   pointer ends the list. The list is reduced by SUM, COUNT, MAX or FIND.
//   One memory read is outstanding at a time; latency is arbitrary (>= 1).
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   start_i      level request, 4-phase handshake with done_o
//   mode_i       0 SUM, 1 COUNT, 2 MAX (unsigned), 3 FIND
//   head_addr_i  first node address, 0 = empty list
//   key_i        FIND compare value
//   mem_req_o    one-cycle read request pulse
//   mem_addr_o   read address, valid while mem_req_o = 1
//   mem_rdata_i  read data, qualified by mem_valid_i
//   mem_valid_i  read data return
//   busy_o       walk in progress
//   done_o       result available (held until start_i drops)
//   result_o     reduction result; FIND: matching node address
//   found_o      FIND matched
//   overflow_o   SUM carried out at least once during this run
//   err_limit_o  node limit reached while the list continued
// -----------------------------------------------------------------------------
module lklist_walker
   import lklist_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned MAX_NODES = 255
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic [1:0]        mode_i,
   input  logic [ADDR_W-1:0] head_addr_i,
   input  logic [DATA_W-1:0] key_i,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_valid_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] result_o,
   output logic              found_o,
   output logic              overflow_o,
   output logic              err_limit_o
);

   state_e            state_q;
   mode_e             mode_q;
   logic [DATA_W-1:0] key_q;
   logic [ADDR_W-1:0] cur_q;
   logic [DATA_W-1:0] acc_q;
   logic [ADDR_W-1:0] node_cnt_q;
   logic              mem_req_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic              busy_q;
   logic              done_q;
   logic [DATA_W-1:0] result_q;
   logic              found_q;
   logic              overflow_q;
   logic              err_limit_q;

   logic [DATA_W-1:0] acc_nxt_s;
   logic              carry_s;
   logic              hit_s;
   logic [ADDR_W-1:0] nxt_ptr_s;
   logic [ADDR_W-1:0] node_cnt_d;
   logic              nxt_null_s;
   logic              at_limit_s;
   logic [DATA_W-1:0] final_result_s;

   lklist_acc #(
      .DATA_W (DATA_W)
   ) u_acc (
      .mode_i    (mode_q),
      .acc_i     (acc_q),
      .v_i       (mem_rdata_i),
      .key_i     (key_q),
      .acc_nxt_o (acc_nxt_s),
      .carry_o   (carry_s),
      .hit_o     (hit_s)
   );

   // Decode the next-pointer return and the node-limit condition.
   always_comb begin
      nxt_ptr_s  = mem_rdata_i[ADDR_W-1:0];
      node_cnt_d = node_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      nxt_null_s = (nxt_ptr_s == ADDR_W'(NULL_PTR));
      at_limit_s = (node_cnt_d == ADDR_W'(MAX_NODES));
      // A FIND that runs off the end of the list reports address 0.
      if (mode_q == MODE_FIND) begin
         final_result_s = '0;
      end else begin
         final_result_s = acc_q;
      end
   end

   // Walker FSM with registered handshake, memory and result outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         mode_q      <= MODE_SUM;
         key_q       <= '0;
         cur_q       <= '0;
         acc_q       <= '0;
         node_cnt_q  <= '0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         result_q    <= '0;
         found_q     <= 1'b0;
         overflow_q  <= 1'b0;
         err_limit_q <= 1'b0;
      end else begin
         // Requests are single-cycle pulses; only the entry into a REQ
         // state raises them again.
         mem_req_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  mode_q      <= mode_e'(mode_i);
                  key_q       <= key_i;
                  cur_q       <= head_addr_i;
                  acc_q       <= '0;
                  node_cnt_q  <= '0;
                  result_q    <= '0;
                  found_q     <= 1'b0;
                  overflow_q  <= 1'b0;
                  err_limit_q <= 1'b0;
                  if (head_addr_i == ADDR_W'(NULL_PTR)) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q    <= ST_REQ_VAL;
                     busy_q     <= 1'b1;
                     mem_req_q  <= 1'b1;
                     mem_addr_q <= head_addr_i;
                  end
               end
            end
            ST_REQ_VAL: begin
               state_q <= ST_WAIT_VAL;
            end
            ST_WAIT_VAL: begin
               if (mem_valid_i) begin
                  if ((mode_q == MODE_FIND) && hit_s) begin
                     // Match: report this node and skip the pointer fetch.
                     result_q <= DATA_W'(cur_q);
                     found_q  <= 1'b1;
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
                     state_q  <= ST_DONE;
                  end else begin
                     acc_q <= acc_nxt_s;
                     if (carry_s) begin
                        overflow_q <= 1'b1;
                     end
                     state_q    <= ST_REQ_NXT;
                     mem_req_q  <= 1'b1;
                     // Pointer word sits right after the value, wrapping.
                     mem_addr_q <= cur_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                  end
               end
            end
            ST_REQ_NXT: begin
               state_q <= ST_WAIT_NXT;
            end
            ST_WAIT_NXT: begin
               if (mem_valid_i) begin
                  node_cnt_q <= node_cnt_d;
                  if (nxt_null_s || at_limit_s) begin
                     // End of list wins over the limit on the same node.
                     err_limit_q <= !nxt_null_s;
                     result_q    <= final_result_s;
                     busy_q      <= 1'b0;
                     done_q      <= 1'b1;
                     state_q     <= ST_DONE;
                  end else begin
                     cur_q      <= nxt_ptr_s;
                     state_q    <= ST_REQ_VAL;
                     mem_req_q  <= 1'b1;
                     mem_addr_q <= nxt_ptr_s;
                  end
               end
            end
            ST_DONE: begin
               if (!start_i) begin
                  done_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign mem_req_o   = mem_req_q;
   assign mem_addr_o  = mem_addr_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign result_o    = result_q;
   assign found_o     = found_q;
   assign overflow_o  = overflow_q;
   assign err_limit_o = err_limit_q;

endmodule : lklist_walker
